// File: rtl/cpu_core.sv
// cpu_core: small accumulator-free load/store core with a two-state sequencer.
//   EXEC executes the instruction presented on q, which is the RAM word
//   at the current address. MEM is the second cycle of a memory op: it
//   writes back load data (or ends a store) and resumes at the saved
//   return address.
// Ports:
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   q             - RAM read data for the currently driven address
//   data          - RAM write data (registered)
//   address       - RAM address (registered)
//   wren          - RAM write enable (registered, high in MEM of stores)
//   stall         - freezes every register and output while high
//   irq, irq_num  - level interrupt request and its vector number
//   irq_ack       - high during the cycle an interrupt is taken
//   status        - {5'b0, in_handler, ie, carry}
module cpu_core #(
  parameter int          DW       = 32,
  parameter int          AW       = 16,
  parameter int          NREG     = 16,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] IRQ_BASE = 64'hFF00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] data,
  output logic [AW-1:0] address,
  output logic          wren,
  input  logic          stall,
  input  logic          irq,
  input  logic [7:0]    irq_num,
  output logic          irq_ack,
  output logic [7:0]    status
);
  localparam int RW = $clog2(NREG);

  localparam logic [0:0] S_EXEC = 1'b0;
  localparam logic [0:0] S_MEM  = 1'b1;

  localparam logic [7:0] OP_LOAD     = 8'h01;
  localparam logic [7:0] OP_STORE    = 8'h02;
  localparam logic [7:0] OP_LOADI    = 8'h03;
  localparam logic [7:0] OP_STORI    = 8'h04;
  localparam logic [7:0] OP_LOADLI   = 8'h05;
  localparam logic [7:0] OP_LOADHI   = 8'h06;
  localparam logic [7:0] OP_LOADLISE = 8'h07;
  localparam logic [7:0] OP_JUMPZ    = 8'h08;
  localparam logic [7:0] OP_JUMPNZ   = 8'h09;
  localparam logic [7:0] OP_JUMPLT   = 8'h0A;
  localparam logic [7:0] OP_JUMPGTE  = 8'h0B;
  localparam logic [7:0] OP_MOV      = 8'h0C;
  localparam logic [7:0] OP_AND      = 8'h0D;
  localparam logic [7:0] OP_OR       = 8'h0E;
  localparam logic [7:0] OP_XOR      = 8'h0F;
  localparam logic [7:0] OP_ADD      = 8'h10;
  localparam logic [7:0] OP_ADDC     = 8'h11;
  localparam logic [7:0] OP_SUB      = 8'h12;
  localparam logic [7:0] OP_MUL      = 8'h13;
  localparam logic [7:0] OP_READSTAT = 8'h16;
  localparam logic [7:0] OP_RETI     = 8'h17;
  localparam logic [7:0] OP_EI       = 8'h18;
  localparam logic [7:0] OP_DI       = 8'h19;

  logic [DW-1:0] rf [NREG];

  logic [0:0]    state, n_state;
  logic [AW-1:0] n_address, epc, n_epc, ret, n_ret;
  logic [DW-1:0] n_data;
  logic          n_wren, carry, n_carry, ie, n_ie, inh, n_inh;
  logic          ld_pend, n_ld_pend;
  logic [RW-1:0] ld_dst, n_ld_dst;

  // decode
  logic [7:0]      op;
  logic [RW-1:0]   r1, r2, r3;
  logic [15:0]     imm;
  logic [DW-1:0]   a, b, c, simm;
  logic [2*DW-1:0] prod;
  logic [AW-1:0]   addr_inc, jmp_tgt, vec;
  logic            take_irq;

  assign op   = q[31:24];
  assign r1   = q[16 +: RW];
  assign r2   = q[8 +: RW];
  assign r3   = q[0 +: RW];
  assign imm  = q[15:0];
  assign a    = rf[r1];
  assign b    = rf[r2];
  assign c    = rf[r3];
  assign simm = {{(DW-16){imm[15]}}, imm};
  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  assign addr_inc = address + AW'(1);
  assign jmp_tgt  = address + AW'(simm);
  assign vec      = AW'(IRQ_BASE + {56'd0, irq_num});

  assign status   = {5'b0, inh, ie, carry};
  assign take_irq = (state == S_EXEC) && irq && ie;
  // stall wins over interrupt entry; reset masks the combinational pulse
  assign irq_ack  = take_irq && !stall && !reset;

  // register-file write ports: port 0 general, port 1 only for MUL high half
  logic          we0, we1;
  logic [RW-1:0] wa0, wa1;
  logic [DW-1:0] wd0, wd1;

  always_comb begin
    n_state   = state;
    n_address = address;
    n_data    = data;
    n_wren    = wren;
    n_carry   = carry;
    n_ie      = ie;
    n_inh     = inh;
    n_epc     = epc;
    n_ret     = ret;
    n_ld_pend = ld_pend;
    n_ld_dst  = ld_dst;
    we0       = 1'b0;
    wa0       = r3;
    wd0       = '0;
    we1       = 1'b0;
    wa1       = r3 + RW'(1);
    wd1       = prod[2*DW-1:DW];

    if (state == S_MEM) begin
      if (ld_pend) begin
        we0 = 1'b1;
        wa0 = ld_dst;
        wd0 = q;
      end
      n_wren    = 1'b0;
      n_address = ret;
      n_state   = S_EXEC;
    end else if (take_irq) begin
      // instruction on q is dropped; it is refetched after RETI
      n_epc     = address;
      n_ie      = 1'b0;
      n_inh     = 1'b1;
      n_address = vec;
    end else begin
      n_address = addr_inc;
      case (op)
        OP_LOADLI: begin
          we0 = 1'b1; wa0 = r1; wd0 = {a[DW-1:16], imm};
        end
        OP_LOADHI: begin
          we0 = 1'b1; wa0 = r1; wd0 = a; wd0[31:16] = imm;
        end
        OP_LOADLISE: begin
          we0 = 1'b1; wa0 = r1; wd0 = simm;
        end
        OP_MOV: begin
          we0 = 1'b1; wa0 = r2; wd0 = a;
        end
        OP_AND: begin we0 = 1'b1; wd0 = a & b; end
        OP_OR:  begin we0 = 1'b1; wd0 = a | b; end
        OP_XOR: begin we0 = 1'b1; wd0 = a ^ b; end
        OP_ADD: begin
          we0 = 1'b1; {n_carry, wd0} = {1'b0, a} + {1'b0, b};
        end
        OP_ADDC: begin
          we0 = 1'b1;
          {n_carry, wd0} = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, carry};
        end
        OP_SUB: begin we0 = 1'b1; wd0 = a - b; end
        OP_MUL: begin
          we0 = 1'b1; wd0 = prod[DW-1:0]; we1 = 1'b1;
        end
        OP_READSTAT: begin
          we0 = 1'b1; wa0 = r1; wd0 = {{(DW-8){1'b0}}, status};
        end
        OP_JUMPZ:   if (a == '0)    n_address = jmp_tgt;
        OP_JUMPNZ:  if (a != '0)    n_address = jmp_tgt;
        OP_JUMPLT:  if (a[DW-1])    n_address = jmp_tgt;
        OP_JUMPGTE: if (!a[DW-1])   n_address = jmp_tgt;
        OP_LOAD, OP_STORE, OP_LOADI, OP_STORI: begin
          n_ret     = addr_inc;
          n_state   = S_MEM;
          n_address = (op == OP_LOADI || op == OP_STORI) ? AW'(imm) : AW'(a + b);
          n_ld_pend = (op == OP_LOAD || op == OP_LOADI);
          n_ld_dst  = (op == OP_LOAD) ? r3 : r1;
          if (op == OP_STORE) begin n_wren = 1'b1; n_data = c; end
          if (op == OP_STORI) begin n_wren = 1'b1; n_data = a; end
        end
        OP_RETI: begin
          n_address = epc; n_ie = 1'b1; n_inh = 1'b0;
        end
        OP_EI:   n_ie = 1'b1;
        OP_DI:   n_ie = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= S_EXEC;
      address <= AW'(RESET_PC);
      data    <= '0;
      wren    <= 1'b0;
      carry   <= 1'b0;
      ie      <= 1'b0;
      inh     <= 1'b0;
      epc     <= AW'(RESET_PC);
      ret     <= '0;
      ld_pend <= 1'b0;
      ld_dst  <= '0;
    end else if (!stall) begin
      state   <= n_state;
      address <= n_address;
      data    <= n_data;
      wren    <= n_wren;
      carry   <= n_carry;
      ie      <= n_ie;
      inh     <= n_inh;
      epc     <= n_epc;
      ret     <= n_ret;
      ld_pend <= n_ld_pend;
      ld_dst  <= n_ld_dst;
    end

  // register file keeps its contents across reset
  always_ff @(posedge clk)
    if (!stall && !reset) begin
      if (we1) rf[wa1] <= wd1;
      if (we0) rf[wa0] <= wd0;
    end

endmodule
